// File: rtl/mcpu_gpu_blit.sv
// mcpu_gpu_blit: VRAM fill/copy engine multiplexed with CPU pass-through on the GPU VRAM port
module mcpu_gpu_blit #(
   parameter int ADDR_W = 13
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [2:0]        i_reg_addr,
   input  logic              i_reg_we,
   input  logic [7:0]        i_reg_wdata,
   output logic [7:0]        o_reg_rdata,
   input  logic [ADDR_W-1:0] i_cpu_vram_addr,
   input  logic              i_cpu_vram_we,
   input  logic [7:0]        i_cpu_vram_wdata,
   input  logic              i_cpu_vram_req,
   output logic              o_cpu_stall,
   output logic [ADDR_W-1:0] o_vram_addr,
   output logic              o_vram_we,
   output logic [7:0]        o_vram_wdata,
   input  logic [7:0]        i_vram_rdata,
   output logic              o_busy,
   output logic              o_done_pulse
);
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_CP_RD, S_CP_WR, S_DONE} state_t;
   state_t r_state, w_next;
   logic [12:0]       r_src, r_dst, r_len, r_rem;
   logic [7:0]        r_fill, r_fv, r_byte;
   logic [ADDR_W-1:0] r_sa, r_da, w_step;
   logic              r_rev, r_done;
   logic              w_cmd, w_go, w_abort;
   assign w_cmd   = i_reg_we && (i_reg_addr == 3'd7);
   assign w_go    = w_cmd && i_reg_wdata[0] && (r_state == S_IDLE || r_state == S_DONE);
   assign w_abort = w_cmd && i_reg_wdata[7];
   assign w_step  = r_rev ? '1 : ADDR_W'(1);
   // programming registers; HI bytes keep only the 5 bits that form a 13-bit value
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_len  <= '0;
         r_fill <= '0;
      end else if (i_reg_we) begin
         case (i_reg_addr)
            3'd0: r_src[7:0]  <= i_reg_wdata;
            3'd1: r_src[12:8] <= i_reg_wdata[4:0];
            3'd2: r_dst[7:0]  <= i_reg_wdata;
            3'd3: r_dst[12:8] <= i_reg_wdata[4:0];
            3'd4: r_len[7:0]  <= i_reg_wdata;
            3'd5: r_len[12:8] <= i_reg_wdata[4:0];
            3'd6: r_fill      <= i_reg_wdata;
            default: ;
         endcase
      end
   end
   // state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end
   // next state: abort from any busy state wins over start and completion
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE, S_DONE: w_next = w_go ? ((r_len == '0) ? S_DONE : (i_reg_wdata[1] ? S_CP_RD : S_FILL)) : S_IDLE;
         S_FILL:         w_next = w_abort ? S_IDLE : ((r_rem > 13'd1) ? S_FILL : S_DONE);
         S_CP_RD:        w_next = w_abort ? S_IDLE : S_CP_WR;
         S_CP_WR:        w_next = w_abort ? S_IDLE : ((r_rem > 13'd1) ? S_CP_RD : S_DONE);
         default:        w_next = S_IDLE;
      endcase
   end
   // working counters: snapshot on start so later register writes cannot disturb a run
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sa   <= '0;
         r_da   <= '0;
         r_rem  <= '0;
         r_fv   <= '0;
         r_rev  <= 1'b0;
         r_byte <= '0;
      end else if (w_go) begin
         r_sa  <= ADDR_W'(r_src);
         r_da  <= ADDR_W'(r_dst);
         r_rem <= r_len;
         r_fv  <= r_fill;
         r_rev <= i_reg_wdata[2];
      end else if (r_state == S_FILL || r_state == S_CP_WR) begin
         r_da  <= r_da + w_step;
         r_rem <= r_rem - 13'd1;
      end else if (r_state == S_CP_RD) begin
         r_sa   <= r_sa + w_step;
         r_byte <= i_vram_rdata;
      end
   end
   // sticky done: set on entering DONE, cleared by an accepted start, untouched by abort
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)            r_done <= 1'b0;
      else if (w_next == S_DONE) r_done <= 1'b1;
      else if (w_go)             r_done <= 1'b0;
   end
   // outputs: engine owns the VRAM port only while busy, otherwise CPU passes through
   always_comb begin
      o_busy       = (r_state == S_FILL) || (r_state == S_CP_RD) || (r_state == S_CP_WR);
      o_done_pulse = (r_state == S_DONE);
      o_cpu_stall  = o_busy && i_cpu_vram_req;
      o_vram_addr  = o_busy ? ((r_state == S_CP_RD) ? r_sa : r_da) : i_cpu_vram_addr;
      o_vram_we    = o_busy ? (r_state != S_CP_RD) : i_cpu_vram_we;
      o_vram_wdata = o_busy ? ((r_state == S_FILL) ? r_fv : r_byte) : i_cpu_vram_wdata;
   end
   // register readback, free of side effects
   always_comb begin
      o_reg_rdata = 8'h00;
      case (i_reg_addr)
         3'd0: o_reg_rdata = r_src[7:0];
         3'd1: o_reg_rdata = {3'b000, r_src[12:8]};
         3'd2: o_reg_rdata = r_dst[7:0];
         3'd3: o_reg_rdata = {3'b000, r_dst[12:8]};
         3'd4: o_reg_rdata = r_len[7:0];
         3'd5: o_reg_rdata = {3'b000, r_len[12:8]};
         3'd6: o_reg_rdata = r_fill;
         default: o_reg_rdata = {6'b0, r_done, o_busy};
      endcase
   end
endmodule
